// File: rtl/adc_result_reader.sv
// -----------------------------------------------------------------------------
// adc_result_reader
// System-clock-side consumer of the SAR-ADC core digital interface.
// - Holds the two configuration words that the ADC core reads.
// - Synchronises the core's asynchronous conversion-finished strobe. Each
//   strobe rise pushes the result word into a small FIFO.
// - Provides a single-cycle register bus. The host uses it to program the
//   configuration words, pop results and read or clear the status.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-high reset
//   conv_finished_in conversion-finished strobe (asynchronous, >= 3 clk high)
//   result_in[15:0]  ADC result, stable from strobe rise to next strobe rise
//   config_1_out     configuration word 1 to the core
//   config_2_out     configuration word 2 to the core
//   bus_addr[1:0]    register address (0 CFG1, 1 CFG2, 2 RESULT, 3 STATUS)
//   bus_wr           one-cycle write strobe
//   bus_wdata[15:0]  write data
//   bus_rd           one-cycle read strobe
//   bus_rdata[15:0]  registered read data, held between reads
//   bus_rdata_valid  one-cycle pulse qualifying bus_rdata
//   irq_out          high while FIFO level >= IRQ_LEVEL
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module adc_result_reader #(
    parameter int          FIFO_DEPTH  = 8,
    parameter int          IRQ_LEVEL   = 1,
    parameter logic [15:0] CONFIG1_RST = 16'h0000,
    parameter logic [15:0] CONFIG2_RST = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        conv_finished_in,
    input  logic [15:0] result_in,
    output logic [15:0] config_1_out,
    output logic [15:0] config_2_out,
    input  logic [1:0]  bus_addr,
    input  logic        bus_wr,
    input  logic [15:0] bus_wdata,
    input  logic        bus_rd,
    output logic [15:0] bus_rdata,
    output logic        bus_rdata_valid,
    output logic        irq_out
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [PW-1:0] FULL_LVL  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] IRQ_LVL   = PW'(IRQ_LEVEL);

    // Synchroniser and edge-detect flops
    logic s1_q, s2_q, s3_q;

    // FIFO state
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          overflow_q, overflow_d;

    // Bus-visible registers
    logic [15:0] cfg1_q, cfg1_d;
    logic [15:0] cfg2_q, cfg2_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q, irq_d;

    // Combinational helpers
    logic [PW-1:0] level_s, level_d;
    logic [6:0]    level7_s;
    logic          empty_s, full_s;
    logic          push_s, pop_s, do_push_s, drop_s;
    logic          rd_ok_s, ovf_clr_s;
    logic [15:0]   status_s, rd_mux_s;

    assign level_s = wr_ptr_q - rd_ptr_q;
    assign empty_s = (level_s == {PW{1'b0}});
    assign full_s  = (level_s == FULL_LVL);

    // One push per strobe rise, seen after two synchroniser stages
    assign push_s    = s2_q & ~s3_q;
    // A simultaneous write wins over a read, so the read is suppressed
    assign rd_ok_s   = bus_rd & ~bus_wr;
    assign pop_s     = rd_ok_s & (bus_addr == 2'd2) & ~empty_s;
    // When full, a push is accepted only if a pop frees the head slot in the same cycle
    assign do_push_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;
    assign ovf_clr_s = bus_wr & (bus_addr == 2'd3) & bus_wdata[15];

    // Zero-extend the level into the 7-bit STATUS field
    always_comb begin
        level7_s = 7'd0;
        level7_s[PW-1:0] = level_s;
    end

    assign status_s = {overflow_q, empty_s, full_s, 6'd0, level7_s};

    // Read-data selection; STATUS reflects the state before any same-cycle push or pop
    always_comb begin
        case (bus_addr)
            2'd0:    rd_mux_s = cfg1_q;
            2'd1:    rd_mux_s = cfg2_q;
            2'd2:    rd_mux_s = empty_s ? 16'h0000 : mem_q[rd_ptr_q[AW-1:0]];
            2'd3:    rd_mux_s = status_s;
            default: rd_mux_s = 16'h0000;
        endcase
    end

    // Next-state logic for pointers, flags and bus registers
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        cfg1_d     = cfg1_q;
        cfg2_d     = cfg2_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;

        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        // A drop in the same cycle as a clear leaves overflow set
        if (drop_s) begin
            overflow_d = 1'b1;
        end else if (ovf_clr_s) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (bus_wr && (bus_addr == 2'd0)) begin
            cfg1_d = bus_wdata;
        end else begin
            cfg1_d = cfg1_q;
        end

        if (bus_wr && (bus_addr == 2'd1)) begin
            cfg2_d = bus_wdata;
        end else begin
            cfg2_d = cfg2_q;
        end

        if (rd_ok_s) begin
            rdata_d  = rd_mux_s;
            rvalid_d = 1'b1;
        end else begin
            rdata_d  = rdata_q;
            rvalid_d = 1'b0;
        end
    end

    assign level_d = wr_ptr_d - rd_ptr_d;
    assign irq_d   = (level_d >= IRQ_LVL);

    // Strobe synchroniser and edge-detect delay flop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= conv_finished_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // FIFO storage; contents do not need a reset because the pointers qualify them
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= result_in;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= {PW{1'b0}};
            rd_ptr_q   <= {PW{1'b0}};
            overflow_q <= 1'b0;
            cfg1_q     <= CONFIG1_RST;
            cfg2_q     <= CONFIG2_RST;
            rdata_q    <= 16'h0000;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            cfg1_q     <= cfg1_d;
            cfg2_q     <= cfg2_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign config_1_out    = cfg1_q;
    assign config_2_out    = cfg2_q;
    assign bus_rdata       = rdata_q;
    assign bus_rdata_valid = rvalid_q;
    assign irq_out         = irq_q;

endmodule

// File: tb/tb_adc_result_reader.sv
// -----------------------------------------------------------------------------
// Testbench for adc_result_reader. A queue-based scoreboard predicts the FIFO
// contents as strobes are driven. Each test task drives one scenario and
// compares the DUT outputs against the bench's own expected values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_adc_result_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        conv_finished_in = 1'b0;
    logic [15:0] result_in = 16'h0000;
    logic [15:0] config_1_out, config_2_out;
    logic [1:0]  bus_addr = 2'd0;
    logic        bus_wr = 1'b0;
    logic [15:0] bus_wdata = 16'h0000;
    logic        bus_rd = 1'b0;
    logic [15:0] bus_rdata;
    logic        bus_rdata_valid;
    logic        irq_out;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q [$];
    logic        model_ovf = 1'b0;
    logic [15:0] got;
    logic        gotv;
    logic [15:0] exp;

    always #5 clk = ~clk;

    adc_result_reader #(
        .FIFO_DEPTH (8),
        .IRQ_LEVEL  (1),
        .CONFIG1_RST(16'h0000),
        .CONFIG2_RST(16'h0000)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .conv_finished_in(conv_finished_in),
        .result_in       (result_in),
        .config_1_out    (config_1_out),
        .config_2_out    (config_2_out),
        .bus_addr        (bus_addr),
        .bus_wr          (bus_wr),
        .bus_wdata       (bus_wdata),
        .bus_rd          (bus_rd),
        .bus_rdata       (bus_rdata),
        .bus_rdata_valid (bus_rdata_valid),
        .irq_out         (irq_out)
    );

    // Every task starts and ends 1 ns after a rising edge.
    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
        @(posedge clk); #1;
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [15:0] d, output logic v);
        bus_addr = a; bus_rd = 1'b1;
        @(posedge clk); #1;
        bus_rd = 1'b0;
        d = bus_rdata; v = bus_rdata_valid;
    endtask

    // Drive one strobe and record the predicted FIFO effect in the scoreboard.
    task automatic strobe(input logic [15:0] val, input int hi);
        result_in = val; conv_finished_in = 1'b1;
        if (exp_q.size() < 8) exp_q.push_back(val);
        else model_ovf = 1'b1;
        repeat (hi) @(posedge clk);
        #1 conv_finished_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] model_status();
        logic [6:0] lv;
        lv = 7'(exp_q.size());
        return {model_ovf, (exp_q.size() == 0), (exp_q.size() == 8), 6'd0, lv};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk); #1;
        checks++; if (config_1_out !== 16'h0000) begin errors++; $display("FAIL rst_cfg1 got=%h exp=%h", config_1_out, 16'h0000); end
        checks++; if (config_2_out !== 16'h0000) begin errors++; $display("FAIL rst_cfg2 got=%h exp=%h", config_2_out, 16'h0000); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL rst_irq got=%b exp=0", irq_out); end
        checks++; if (bus_rdata_valid !== 1'b0 || bus_rdata !== 16'h0000) begin errors++; $display("FAIL rst_rdata got=%h/%b exp=0000/0", bus_rdata, bus_rdata_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000 || gotv !== 1'b1) begin errors++; $display("FAIL rst_status got=%h/%b exp=4000/1", got, gotv); end
    endtask

    task automatic test_config();
        bus_write(2'd0, 16'h00A5);
        checks++; if (config_1_out !== 16'h00A5) begin errors++; $display("FAIL cfg1_out got=%h exp=00a5", config_1_out); end
        bus_write(2'd1, 16'h1234);
        checks++; if (config_2_out !== 16'h1234) begin errors++; $display("FAIL cfg2_out got=%h exp=1234", config_2_out); end
        bus_read(2'd0, got, gotv);
        checks++; if (got !== 16'h00A5 || gotv !== 1'b1) begin errors++; $display("FAIL cfg1_rd got=%h/%b exp=00a5/1", got, gotv); end
        bus_read(2'd1, got, gotv);
        checks++; if (got !== 16'h1234 || gotv !== 1'b1) begin errors++; $display("FAIL cfg2_rd got=%h/%b exp=1234/1", got, gotv); end
        @(posedge clk); #1;
        checks++; if (bus_rdata !== 16'h1234 || bus_rdata_valid !== 1'b0) begin errors++; $display("FAIL rdata_hold got=%h/%b exp=1234/0", bus_rdata, bus_rdata_valid); end
        // Write to RESULT has no effect
        bus_write(2'd2, 16'hFFFF);
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL wr_result_ignored got=%h exp=4000", got); end
        // Read and write together: write done, read dropped
        bus_addr = 2'd0; bus_wdata = 16'h0055; bus_wr = 1'b1; bus_rd = 1'b1;
        @(posedge clk); #1;
        bus_wr = 1'b0; bus_rd = 1'b0;
        checks++; if (bus_rdata_valid !== 1'b0) begin errors++; $display("FAIL rdwr_novalid got=%b exp=0", bus_rdata_valid); end
        checks++; if (config_1_out !== 16'h0055) begin errors++; $display("FAIL rdwr_write got=%h exp=0055", config_1_out); end
    endtask

    task automatic test_single_capture();
        strobe(16'h0ABC, 4);
        checks++; if (irq_out !== 1'b1) begin errors++; $display("FAIL single_irq got=%b exp=1", irq_out); end
        exp = model_status();
        bus_read(2'd3, got, gotv);
        checks++; if (got !== exp) begin errors++; $display("FAIL single_status got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front();
        bus_read(2'd2, got, gotv);
        checks++; if (got !== exp || gotv !== 1'b1) begin errors++; $display("FAIL single_data got=%h/%b exp=%h/1", got, gotv, exp); end
        checks++; if (irq_out !== 1'b0) begin errors++; $display("FAIL single_irq_clr got=%b exp=0", irq_out); end
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL single_status2 got=%h exp=4000", got); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 9; i++) strobe(16'(i), 3);
        exp = model_status();
        bus_read(2'd3, got, gotv);
        checks++; if (got !== exp || got !== 16'hA008) begin errors++; $display("FAIL ovf_status got=%h exp=%h", got, exp); end
        for (int i = 0; i < 9; i++) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'h0000;
            bus_read(2'd2, got, gotv);
            checks++; if (got !== exp || gotv !== 1'b1) begin errors++; $display("FAIL ovf_data[%0d] got=%h/%b exp=%h/1", i, got, gotv, exp); end
        end
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'hC000) begin errors++; $display("FAIL ovf_sticky got=%h exp=c000", got); end
        bus_write(2'd3, 16'h8000);
        model_ovf = 1'b0;
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL ovf_clear got=%h exp=4000", got); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < 8; i++) strobe(16'h0100 + 16'(i), 3);
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h2008) begin errors++; $display("FAIL full_status got=%h exp=2008", got); end
        // Place the RESULT read in exactly the cycle where the push happens.
        result_in = 16'h0F0F; conv_finished_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus_addr = 2'd2; bus_rd = 1'b1;
        @(posedge clk); #1;
        bus_rd = 1'b0;
        exp = exp_q.pop_front();
        exp_q.push_back(16'h0F0F);
        checks++; if (bus_rdata !== exp || bus_rdata_valid !== 1'b1) begin errors++; $display("FAIL pp_data got=%h/%b exp=%h/1", bus_rdata, bus_rdata_valid, exp); end
        @(posedge clk); #1 conv_finished_in = 1'b0;
        repeat (4) @(posedge clk); #1;
        exp = model_status();
        bus_read(2'd3, got, gotv);
        checks++; if (got !== exp || got !== 16'h2008) begin errors++; $display("FAIL pp_status got=%h exp=%h", got, exp); end
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            bus_read(2'd2, got, gotv);
            checks++; if (got !== exp) begin errors++; $display("FAIL pp_drain[%0d] got=%h exp=%h", i, got, exp); end
        end
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL pp_empty got=%h exp=4000", got); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) strobe(16'h00A1 + 16'(i), 3);
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h0003) begin errors++; $display("FAIL ar_level3 got=%h exp=0003", got); end
        // Raise a strobe, let it reach s2, then reset before the push edge.
        result_in = 16'hBEEF; conv_finished_in = 1'b1;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++; if (irq_out !== 1'b0 || config_1_out !== 16'h0000) begin errors++; $display("FAIL ar_immediate got=irq %b cfg1 %h exp=irq 0 cfg1 0000", irq_out, config_1_out); end
        conv_finished_in = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        repeat (5) @(posedge clk); #1;
        bus_read(2'd3, got, gotv);
        checks++; if (got !== 16'h4000) begin errors++; $display("FAIL ar_no_push got=%h exp=4000", got); end
        // A strobe held high across reset release yields exactly one push.
        rst = 1'b1; result_in = 16'hCAFE; conv_finished_in = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back(16'hCAFE);
        repeat (4) @(posedge clk); #1 conv_finished_in = 1'b0;
        repeat (4) @(posedge clk); #1;
        exp = model_status();
        bus_read(2'd3, got, gotv);
        checks++; if (got !== exp) begin errors++; $display("FAIL ar_held_status got=%h exp=%h", got, exp); end
        exp = exp_q.pop_front();
        bus_read(2'd2, got, gotv);
        checks++; if (got !== exp) begin errors++; $display("FAIL ar_held_data got=%h exp=%h", got, exp); end
    endtask

    initial begin
        #1;
        test_reset();
        test_config();
        test_single_capture();
        test_overflow();
        test_push_pop_full();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
